// File: rtl/ni_packetizer.sv
// Local-port injection stage: turns a packet descriptor plus a payload-word stream
// into HEAD/BODY/TAIL (or HEADTAIL) flits on one allocated VC, with per-VC on/off backpressure.

package ni_packetizer_pkg;

    localparam int VC_NUM            = 4;
    localparam int VC_SIZE           = $clog2(VC_NUM);
    localparam int DEST_ADDR_SIZE_X  = 4;
    localparam int DEST_ADDR_SIZE_Y  = 4;
    localparam int FLIT_DATA_SIZE    = 16;
    localparam int HEAD_PAYLOAD_SIZE = FLIT_DATA_SIZE - DEST_ADDR_SIZE_X - DEST_ADDR_SIZE_Y;

    typedef enum logic [1:0] {
        HEAD     = 2'b00,
        BODY     = 2'b01,
        TAIL     = 2'b10,
        HEADTAIL = 2'b11
    } flit_label_t;

    typedef struct packed {
        logic [DEST_ADDR_SIZE_X-1:0]  x_dest;
        logic [DEST_ADDR_SIZE_Y-1:0]  y_dest;
        logic [HEAD_PAYLOAD_SIZE-1:0] head_pl;
    } head_data_t;

    typedef union packed {
        head_data_t                head_data;
        logic [FLIT_DATA_SIZE-1:0] bt_pl;
    } flit_data_t;

    typedef struct packed {
        flit_label_t          flit_label;
        logic [VC_SIZE-1:0]   vc_id;
        flit_data_t           data;
    } flit_t;

endpackage

module ni_packetizer
    import ni_packetizer_pkg::*;
#(
    parameter int MAX_PKT_FLITS = 8,
    parameter int ALLOC_HOLD    = 2
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 pkt_valid_i,
    output logic                                 pkt_ready_o,
    input  logic [DEST_ADDR_SIZE_X-1:0]          x_dest_i,
    input  logic [DEST_ADDR_SIZE_Y-1:0]          y_dest_i,
    input  logic [$clog2(MAX_PKT_FLITS+1)-1:0]   pkt_size_i,
    input  logic                                 pl_valid_i,
    output logic                                 pl_ready_o,
    input  logic [FLIT_DATA_SIZE-1:0]            pl_data_i,
    output flit_t                                data_o,
    output logic                                 valid_flit_o,
    input  logic [VC_NUM-1:0]                    on_off_i,
    input  logic [VC_NUM-1:0]                    vc_allocatable_i,
    output logic                                 busy_o,
    output logic                                 error_o
);

    localparam int SIZE_W = $clog2(MAX_PKT_FLITS + 1);
    localparam int HOLD_W = (ALLOC_HOLD > 0) ? $clog2(ALLOC_HOLD + 1) : 1;
    localparam logic [SIZE_W-1:0] MAX_SIZE = SIZE_W'(MAX_PKT_FLITS);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        ALLOC = 2'b01,
        SEND  = 2'b10
    } state_t;

    state_t                      state_reg, state_next;
    logic [DEST_ADDR_SIZE_X-1:0] x_reg;
    logic [DEST_ADDR_SIZE_Y-1:0] y_reg;
    logic [SIZE_W-1:0]           size_reg;
    logic [SIZE_W-1:0]           cnt_reg;
    logic [VC_SIZE-1:0]          cur_vc_reg;
    logic [VC_NUM-1:0]           mask_reg;
    logic [HOLD_W-1:0]           hold_reg;
    flit_t                       data_reg;
    logic                        valid_reg;
    logic                        error_reg;

    logic                        size_zero, size_over;
    logic [SIZE_W-1:0]           size_fixed;
    logic [VC_NUM-1:0]           eligible, grant;
    logic [VC_NUM:0]             found_below;
    logic [VC_SIZE-1:0]          grant_idx;
    logic                        any_eligible;
    logic                        pl_ready, handshake, last_flit;
    flit_t                       flit_next;

    // Descriptor sanitising: empty packets become one flit, oversize ones are clamped.
    assign size_zero  = (pkt_size_i == '0);
    assign size_over  = (pkt_size_i > MAX_SIZE);
    assign size_fixed = size_zero ? SIZE_W'(1) : (size_over ? MAX_SIZE : pkt_size_i);

    // Lowest-index eligible VC via a ripple "someone below already won" chain.
    assign found_below[0] = 1'b0;
    for (genvar gi = 0; gi < VC_NUM; gi++) begin : g_pick
        assign eligible[gi]       = vc_allocatable_i[gi] & ~mask_reg[gi];
        assign grant[gi]          = eligible[gi] & ~found_below[gi];
        assign found_below[gi+1]  = found_below[gi] | eligible[gi];
    end
    assign any_eligible = found_below[VC_NUM];

    always_comb begin
        grant_idx = '0;
        for (int v = 0; v < VC_NUM; v++) begin
            if (grant[v]) begin
                grant_idx = VC_SIZE'(v);
            end
        end
    end

    assign last_flit = (cnt_reg == size_reg - 1'b1);

    always_comb begin
        flit_next       = '0;
        flit_next.vc_id = cur_vc_reg;
        if (cnt_reg == '0) begin
            flit_next.flit_label             = (size_reg == SIZE_W'(1)) ? HEADTAIL : HEAD;
            flit_next.data.head_data.x_dest  = x_reg;
            flit_next.data.head_data.y_dest  = y_reg;
            flit_next.data.head_data.head_pl = pl_data_i[HEAD_PAYLOAD_SIZE-1:0];
        end else begin
            flit_next.flit_label = last_flit ? TAIL : BODY;
            flit_next.data.bt_pl = pl_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        pkt_ready_o = 1'b0;
        pl_ready    = 1'b0;
        handshake   = 1'b0;
        case (state_reg)
            IDLE: begin
                pkt_ready_o = 1'b1;
                if (pkt_valid_i) begin
                    state_next = ALLOC;
                end
            end
            ALLOC: begin
                if (any_eligible) begin
                    state_next = SEND;
                end
            end
            SEND: begin
                pl_ready  = on_off_i[cur_vc_reg];
                handshake = pl_valid_i & pl_ready;
                if (handshake && last_flit) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            x_reg      <= '0;
            y_reg      <= '0;
            size_reg   <= '0;
            cnt_reg    <= '0;
            cur_vc_reg <= '0;
            mask_reg   <= '0;
            hold_reg   <= '0;
            data_reg   <= '0;
            valid_reg  <= 1'b0;
            error_reg  <= 1'b0;
        end else begin
            valid_reg <= 1'b0;
            error_reg <= 1'b0;

            if (hold_reg != '0) begin
                hold_reg <= hold_reg - 1'b1;
                if (hold_reg == HOLD_W'(1)) begin
                    mask_reg <= '0;
                end
            end

            case (state_reg)
                IDLE: begin
                    if (pkt_valid_i) begin
                        x_reg     <= x_dest_i;
                        y_reg     <= y_dest_i;
                        size_reg  <= size_fixed;
                        cnt_reg   <= '0;
                        error_reg <= size_zero | size_over;
                    end
                end
                ALLOC: begin
                    if (any_eligible) begin
                        cur_vc_reg <= grant_idx;
                    end
                end
                SEND: begin
                    if (handshake) begin
                        data_reg  <= flit_next;
                        valid_reg <= 1'b1;
                        if (last_flit) begin
                            cnt_reg <= '0;
                            // Keep the just-finished VC out of the next allocation briefly.
                            if (ALLOC_HOLD > 0) begin
                                mask_reg <= VC_NUM'(1) << cur_vc_reg;
                                hold_reg <= HOLD_W'(ALLOC_HOLD);
                            end
                        end else begin
                            cnt_reg <= cnt_reg + 1'b1;
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign data_o       = data_reg;
    assign valid_flit_o = valid_reg;
    assign pl_ready_o   = pl_ready;
    assign busy_o       = (state_reg != IDLE);
    assign error_o      = error_reg;

endmodule

// File: tb/tb_ni_packetizer.sv
// Directed bench for ni_packetizer: flits are captured by a monitor and compared
// against hand-derived label/VC/payload sequences for each scenario.

module tb_ni_packetizer;
    import ni_packetizer_pkg::*;

    localparam int MAXF = 8;
    localparam int SW   = $clog2(MAXF + 1);

    logic                        clk = 1'b0;
    logic                        rst = 1'b1;
    logic                        pkt_valid = 1'b0;
    logic                        pkt_ready;
    logic [DEST_ADDR_SIZE_X-1:0] x_dest = '0;
    logic [DEST_ADDR_SIZE_Y-1:0] y_dest = '0;
    logic [SW-1:0]               pkt_size = '0;
    logic                        pl_valid = 1'b0;
    logic                        pl_ready;
    logic [FLIT_DATA_SIZE-1:0]   pl_data = '0;
    flit_t                       data;
    logic                        valid_flit;
    logic [VC_NUM-1:0]           on_off = '1;
    logic [VC_NUM-1:0]           vc_alloc = '1;
    logic                        busy;
    logic                        error;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int hs_total = 0;
    int err_cnt = 0;
    logic hs_seen = 1'b0;

    logic [FLIT_DATA_SIZE-1:0] pl_q[$];
    flit_t                     got_q[$];
    int                        fcyc_q[$];
    int                        hs_cyc_q[$];

    ni_packetizer #(.MAX_PKT_FLITS(MAXF), .ALLOC_HOLD(2)) dut (
        .clk              (clk),
        .rst              (rst),
        .pkt_valid_i      (pkt_valid),
        .pkt_ready_o      (pkt_ready),
        .x_dest_i         (x_dest),
        .y_dest_i         (y_dest),
        .pkt_size_i       (pkt_size),
        .pl_valid_i       (pl_valid),
        .pl_ready_o       (pl_ready),
        .pl_data_i        (pl_data),
        .data_o           (data),
        .valid_flit_o     (valid_flit),
        .on_off_i         (on_off),
        .vc_allocatable_i (vc_alloc),
        .busy_o           (busy),
        .error_o          (error)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            @(posedge clk);
            cyc++;
        end
    end

    // Monitor: handshakes, emitted flits and error pulses, sampled mid-cycle.
    initial begin
        forever begin
            @(negedge clk);
            hs_seen = pl_valid && pl_ready;
            if (hs_seen) begin
                hs_total++;
                hs_cyc_q.push_back(cyc);
            end
            if (valid_flit) begin
                got_q.push_back(data);
                fcyc_q.push_back(cyc);
            end
            if (error) err_cnt++;
        end
    end

    // Payload feeder: presents the head of pl_q, pops it once consumed.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (hs_seen && pl_q.size() > 0) void'(pl_q.pop_front());
            if (pl_q.size() > 0) begin
                pl_valid = 1'b1;
                pl_data  = pl_q[0];
            end else begin
                pl_valid = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end else begin
            $display("ok   %s = 0x%0h", tag, got);
        end
    endtask

    task automatic clear_q();
        got_q.delete();
        fcyc_q.delete();
        hs_cyc_q.delete();
    endtask

    task automatic put_desc(input int x, input int y, input int size);
        int n;
        @(posedge clk);
        #1;
        x_dest    = DEST_ADDR_SIZE_X'(x);
        y_dest    = DEST_ADDR_SIZE_Y'(y);
        pkt_size  = SW'(size);
        pkt_valid = 1'b1;
        n = 0;
        forever begin
            @(negedge clk);
            if (pkt_ready) break;
            n++;
            if (n > 200) begin
                check("desc accept", 32'(pkt_ready), 32'(1));
                break;
            end
        end
        @(posedge clk);
        #1;
        pkt_valid = 1'b0;
    endtask

    task automatic wait_flits(input int n, input string tag);
        int k;
        k = 0;
        while (got_q.size() < n && k < 300) begin
            @(posedge clk);
            #2;
            k++;
        end
        repeat (4) @(posedge clk);
        #2;
        check({tag, " flit count"}, 32'(got_q.size()), 32'(n));
    endtask

    task automatic drain();
        int k;
        k = 0;
        while ((busy || pl_q.size() != 0) && k < 300) begin
            @(posedge clk);
            #1;
            k++;
        end
        check("drain idle", 32'(busy), 32'(0));
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic check_flit(input string tag, input flit_label_t label, input int vc,
                              input int pl, input int x, input int y, output int fc);
        flit_t f;
        fc = -1;
        if (got_q.size() == 0) return;
        f  = got_q.pop_front();
        fc = fcyc_q.pop_front();
        check({tag, " label"}, 32'(f.flit_label), 32'(label));
        check({tag, " vc"}, 32'(f.vc_id), 32'(vc));
        if (label == HEAD || label == HEADTAIL) begin
            check({tag, " x"}, 32'(f.data.head_data.x_dest), 32'(x));
            check({tag, " y"}, 32'(f.data.head_data.y_dest), 32'(y));
            check({tag, " head_pl"}, 32'(f.data.head_data.head_pl), 32'(pl));
        end else begin
            check({tag, " bt_pl"}, 32'(f.data.bt_pl), 32'(pl));
        end
    endtask

    initial begin
        int c0, c1, c2, c3, e0, base, k;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst valid_flit", 32'(valid_flit), 32'(0));
        check("rst pkt_ready", 32'(pkt_ready), 32'(1));
        check("rst pl_ready", 32'(pl_ready), 32'(0));
        check("rst busy", 32'(busy), 32'(0));
        check("rst error", 32'(error), 32'(0));
        check("rst data", 32'(data), 32'(0));

        // Basic 4-flit packet, head payload truncated to 8 bits
        clear_q();
        e0 = err_cnt;
        pl_q.push_back(16'h550A);
        pl_q.push_back(16'h000B);
        pl_q.push_back(16'h000C);
        pl_q.push_back(16'h000D);
        put_desc(2, 2, 4);
        wait_flits(4, "t1");
        check_flit("t1 f0", HEAD, 0, 'h0A, 2, 2, c0);
        check_flit("t1 f1", BODY, 0, 'h0B, 0, 0, c1);
        check_flit("t1 f2", BODY, 0, 'h0C, 0, 0, c2);
        check_flit("t1 f3", TAIL, 0, 'h0D, 0, 0, c3);
        if (hs_cyc_q.size() > 0) check("t1 latency", 32'(c0 - hs_cyc_q[0]), 32'(1));
        check("t1 back-to-back", 32'(c3 - c0), 32'(3));
        check("t1 no error", 32'(err_cnt - e0), 32'(0));

        // Single-flit packets: second is pushed onto VC1 by the hold mask
        drain();
        clear_q();
        pl_q.push_back(16'h0011);
        pl_q.push_back(16'h0012);
        put_desc(1, 3, 1);
        put_desc(3, 1, 1);
        wait_flits(2, "t2");
        check_flit("t2 p1", HEADTAIL, 0, 'h11, 1, 3, c0);
        check_flit("t2 p2", HEADTAIL, 1, 'h12, 3, 1, c1);
        repeat (4) @(posedge clk);
        #1;
        pl_q.push_back(16'h0013);
        put_desc(0, 0, 1);
        wait_flits(1, "t2c");
        check_flit("t2 p3", HEADTAIL, 0, 'h13, 0, 0, c0);

        // Allocation stall, then only VC2 offered
        drain();
        clear_q();
        vc_alloc = '0;
        pl_q.push_back(16'h0021);
        pl_q.push_back(16'h0022);
        put_desc(4, 5, 2);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check($sformatf("t3 stall%0d busy", i), 32'(busy), 32'(1));
            check($sformatf("t3 stall%0d pl_ready", i), 32'(pl_ready), 32'(0));
            @(posedge clk);
            #1;
        end
        vc_alloc = 4'b0100;
        wait_flits(2, "t3");
        check_flit("t3 f0", HEAD, 2, 'h21, 4, 5, c0);
        check_flit("t3 f1", TAIL, 2, 'h22, 0, 0, c1);
        vc_alloc = '1;

        // on/off backpressure for 3 cycles after the HEAD
        drain();
        clear_q();
        pl_q.push_back(16'h0031);
        pl_q.push_back(16'h0032);
        pl_q.push_back(16'h0033);
        pl_q.push_back(16'h0034);
        base = hs_total;
        put_desc(6, 7, 4);
        k = 0;
        while (hs_total < base + 1 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        on_off = 4'b1110;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check($sformatf("t4 off%0d pl_ready", i), 32'(pl_ready), 32'(0));
            @(posedge clk);
            #1;
            check($sformatf("t4 off%0d valid", i), 32'(valid_flit), 32'(0));
        end
        on_off = '1;
        wait_flits(4, "t4");
        check_flit("t4 f0", HEAD, 0, 'h31, 6, 7, c0);
        check_flit("t4 f1", BODY, 0, 'h32, 0, 0, c1);
        check_flit("t4 f2", BODY, 0, 'h33, 0, 0, c2);
        check_flit("t4 f3", TAIL, 0, 'h34, 0, 0, c3);
        check("t4 gap", 32'(c1 - c0), 32'(4));
        check("t4 resume", 32'(c3 - c1), 32'(2));

        // Illegal sizes: 0 -> one flit, 15 -> clamped to 8
        drain();
        clear_q();
        e0 = err_cnt;
        pl_q.push_back(16'h0041);
        put_desc(1, 1, 0);
        wait_flits(1, "t5a");
        check_flit("t5a f0", HEADTAIL, 0, 'h41, 1, 1, c0);
        check("t5a error pulses", 32'(err_cnt - e0), 32'(1));
        drain();
        clear_q();
        e0 = err_cnt;
        for (int i = 0; i < 8; i++) pl_q.push_back(FLIT_DATA_SIZE'(16'h0050 + i));
        put_desc(2, 3, 15);
        wait_flits(8, "t5b");
        check_flit("t5b f0", HEAD, 0, 'h50, 2, 3, c0);
        for (int i = 1; i < 7; i++) begin
            check_flit($sformatf("t5b f%0d", i), BODY, 0, 'h50 + i, 0, 0, c1);
        end
        check_flit("t5b f7", TAIL, 0, 'h57, 0, 0, c1);
        check("t5b error pulses", 32'(err_cnt - e0), 32'(1));

        // Reset in the middle of a packet
        drain();
        clear_q();
        pl_q.push_back(16'h0061);
        pl_q.push_back(16'h0062);
        pl_q.push_back(16'h0063);
        pl_q.push_back(16'h0064);
        base = hs_total;
        put_desc(5, 5, 4);
        k = 0;
        while (hs_total < base + 2 && k < 100) begin
            @(posedge clk);
            #1;
            k++;
        end
        rst = 1'b1;
        pl_q.delete();
        pl_valid = 1'b0;
        @(posedge clk);
        #1;
        check("t6 rst valid_flit", 32'(valid_flit), 32'(0));
        check("t6 rst pkt_ready", 32'(pkt_ready), 32'(1));
        check("t6 rst busy", 32'(busy), 32'(0));
        check("t6 rst pl_ready", 32'(pl_ready), 32'(0));
        check("t6 rst data", 32'(data), 32'(0));
        rst = 1'b0;
        wait_flits(2, "t6 pre");
        check_flit("t6 pre f0", HEAD, 0, 'h61, 5, 5, c0);
        check_flit("t6 pre f1", BODY, 0, 'h62, 0, 0, c1);
        pl_q.push_back(16'h0071);
        pl_q.push_back(16'h0072);
        put_desc(0, 1, 2);
        wait_flits(2, "t6 post");
        check_flit("t6 post f0", HEAD, 0, 'h71, 0, 1, c0);
        check_flit("t6 post f1", TAIL, 0, 'h72, 0, 0, c1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
